tx_metaframer: RTL

Parametrised Interlaken lane transmit framer, successor to the fixed-length TX interface. It accepts 64-bit payload words over a valid/ready handshake, buffers them in a small FIFO, and builds a 64b/67b meta-frame of configurable length: sync, scrambler state, skip, payload/idle and diagnostic words. It emits one word per gearbox slot, paced by a parametrised fractional slot generator, and sits between user logic and the lane scrambler/gearbox.

---
 rtl/tx_metaframer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tx_metaframer.sv
// Interlaken lane transmit framer: buffers payload words and emits one framed
// 64b/67b word per fractional gearbox slot, wrapping payload in control words.
module tx_metaframer #(
    parameter int META_FRAME_LEN = 16,
    parameter int SLOT_NUM       = 20,
    parameter int SLOT_DEN       = 67,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic [63:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    input  logic [57:0] SCRAMBLER_STATE_IN,
    input  logic [1:0]  LANE_STATUS,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_VALID,
    output logic        FRAME_START,
    output logic        IDLE_INSERT,
    output logic        GEARBOX_VALID
);
    localparam int AW = $clog2(SLOT_DEN) + 1;
    localparam int PW = $clog2(META_FRAME_LEN);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    localparam logic [1:0]  HDR_DATA  = 2'b01;
    localparam logic [1:0]  HDR_CTRL  = 2'b10;
    localparam logic [63:0] SYNC_WORD = 64'h78F678F678F678F6;
    localparam logic [63:0] SKIP_WORD = 64'h1E00000000000000;
    localparam logic [63:0] IDLE_WORD = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] DIAG_BASE = 64'h6400000000000000;
    localparam logic [PW-1:0] LAST_POS = PW'(META_FRAME_LEN - 1);

    logic [AW-1:0] acc_q, acc_d;
    logic [AW:0]   sum;
    logic          slot;
    logic [PW-1:0] pos_q, pos_d;
    logic          is_payload;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    logic [63:0]   data_q, data_d;
    logic [1:0]    hdr_q, hdr_d;
    logic          dv_q, dv_d, fs_q, fs_d, idle_q, idle_d, gv_q, gv_d;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign DATA_IN_READY = !SYSTEM_RESET && !full;
    assign push  = DATA_IN_VALID && DATA_IN_READY;

    always_comb begin
        sum   = {1'b0, acc_q} + (AW + 1)'(SLOT_NUM);
        slot  = (sum >= (AW + 1)'(SLOT_DEN));
        acc_d = slot ? AW'(sum - (AW + 1)'(SLOT_DEN)) : AW'(sum);

        pos_d = pos_q;
        if (slot) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + PW'(1);
        end

        is_payload = (pos_q != PW'(0)) && (pos_q != PW'(1)) &&
                     (pos_q != PW'(2)) && (pos_q != LAST_POS);
        // Pop decision uses registered occupancy, so a same-cycle push is never bypassed.
        pop = slot && is_payload && !empty;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        data_d = '0;
        hdr_d  = '0;
        dv_d   = slot;
        fs_d   = 1'b0;
        idle_d = 1'b0;
        gv_d   = gv_q | slot;
        if (slot) begin
            hdr_d = HDR_CTRL;
            if (pos_q == PW'(0)) begin
                data_d = SYNC_WORD;
                fs_d   = 1'b1;
            end else if (pos_q == PW'(1)) begin
                data_d = {6'b001010, SCRAMBLER_STATE_IN};
            end else if (pos_q == PW'(2)) begin
                data_d = SKIP_WORD;
            end else if (pos_q == LAST_POS) begin
                // CRC32 field in the low half is left zero for the downstream CRC stage.
                data_d = DIAG_BASE | {30'b0, LANE_STATUS, 32'b0};
            end else if (!empty) begin
                data_d = mem_q[rd_ptr_q];
                hdr_d  = HDR_DATA;
            end else begin
                data_d = IDLE_WORD;
                idle_d = 1'b1;
            end
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            acc_q    <= '0;
            pos_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            hdr_q    <= '0;
            dv_q     <= 1'b0;
            fs_q     <= 1'b0;
            idle_q   <= 1'b0;
            gv_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            pos_q    <= pos_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            hdr_q    <= hdr_d;
            dv_q     <= dv_d;
            fs_q     <= fs_d;
            idle_q   <= idle_d;
            gv_q     <= gv_d;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    // Outputs are forced low for the whole reset window, including its first cycle.
    assign DATA_OUT      = SYSTEM_RESET ? '0 : data_q;
    assign HEADER_OUT    = SYSTEM_RESET ? '0 : hdr_q;
    assign DATA_VALID    = !SYSTEM_RESET && dv_q;
    assign FRAME_START   = !SYSTEM_RESET && fs_q;
    assign IDLE_INSERT   = !SYSTEM_RESET && idle_q;
    assign GEARBOX_VALID = !SYSTEM_RESET && gv_q;
endmodule
